// File: rtl/flow_ctrl_pkg.sv
// Shared types and constants for the L-K flow frame scheduler.
package flow_ctrl_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_RESULT = 2'd3
    } sched_state_e;

    localparam bank_idx_t WR_BANK_RST   = 2'd0;
    localparam bank_idx_t CURR_BANK_RST = 2'd1;
    localparam bank_idx_t PREV_BANK_RST = 2'd2;

endpackage

// File: rtl/frame_scheduler_watchdog.sv
// Solve watchdog: cleared on launch, counts while the sequencer runs, and pulses
// expire on the cycle that would bring the count to TIMEOUT_CYCLES-1.
module frame_watchdog #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expire) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame-level controller: rotates three frame banks between capture and solver and
// launches the pixel sequencer once per frame. Optional counters under FRAME_STATS_EN.
module frame_scheduler
    import flow_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 frame_in,
    output logic [1:0]           wr_bank,
    output logic [1:0]           prev_bank,
    output logic [1:0]           curr_bank,
    output logic                 seq_start,
    input  logic                 seq_done,
    output logic                 busy,
    output logic                 flow_valid,
    input  logic                 flow_ack,
    output logic                 timeout_err
`ifdef FRAME_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
`endif
);

    sched_state_e state_q, state_d;
    bank_idx_t    wr_q, wr_d, curr_q, curr_d, prev_q, prev_d;
    logic         primed_q, primed_d;
    logic         pending_q, pending_d;
    logic         seq_start_q, seq_start_d;
    logic         flow_valid_q, flow_valid_d;
    logic         timeout_err_q, timeout_err_d;
    logic         rotate;
    logic         timed_out;
    logic         wd_expire;

    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == S_START),
        .run   (state_q == S_RUN),
        .expire(wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        primed_d  = primed_q;
        pending_d = pending_q;
        rotate    = 1'b0;
        timed_out = 1'b0;

        // While busy the solver reads prev/curr, so a new frame only marks pending;
        // a second one before launch overwrites wr_bank in place (a drop).
        if (state_q != S_IDLE && frame_in) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && (frame_in || pending_q)) begin
                    rotate    = 1'b1;
                    pending_d = 1'b0;
                    if (primed_q) begin
                        state_d = S_START;
                    end else begin
                        primed_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (seq_done) begin
                    state_d = S_RESULT;
                end else if (wd_expire) begin
                    state_d   = S_IDLE;
                    timed_out = 1'b1;
                end
            end
            S_RESULT: begin
                if (flow_ack) begin
                    if (enable && (pending_q || frame_in)) begin
                        rotate    = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d   = wr_q;
        curr_d = curr_q;
        prev_d = prev_q;
        if (rotate) begin
            prev_d = curr_q;
            curr_d = wr_q;
            wr_d   = prev_q;
        end
    end

    assign seq_start_d   = (state_d == S_START);
    assign flow_valid_d  = (state_d == S_RESULT);
    // Setting wins over the enable-low clear so an expiry is never lost.
    assign timeout_err_d = timed_out || (timeout_err_q && enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wr_q          <= WR_BANK_RST;
            curr_q        <= CURR_BANK_RST;
            prev_q        <= PREV_BANK_RST;
            primed_q      <= 1'b0;
            pending_q     <= 1'b0;
            seq_start_q   <= 1'b0;
            flow_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            curr_q        <= curr_d;
            prev_q        <= prev_d;
            primed_q      <= primed_d;
            pending_q     <= pending_d;
            seq_start_q   <= seq_start_d;
            flow_valid_q  <= flow_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef FRAME_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 solve_done;
    logic                 drop;

    assign solve_done = (state_q == S_RUN) && seq_done;
    assign drop       = frame_in && pending_q && ((state_q != S_IDLE) || enable);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (solve_done) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end
        if (drop) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

    assign wr_bank     = wr_q;
    assign curr_bank   = curr_q;
    assign prev_bank   = prev_q;
    assign seq_start   = seq_start_q;
    assign flow_valid  = flow_valid_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios plus a randomized run against a
// queue-based reference model. Build with FRAME_STATS_EN to also check the counters.
module tb_frame_scheduler;

    localparam int TIMEOUT = 64;
    localparam int CW      = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_in = 1'b0;
    logic       seq_done = 1'b0;
    logic       flow_ack = 1'b0;
    logic [1:0] wr_bank, prev_bank, curr_bank;
    logic       seq_start, busy, flow_valid, timeout_err;
`ifdef FRAME_STATS_EN
    logic [CW-1:0] frame_cnt, drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    frame_scheduler #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_in   (frame_in),
        .wr_bank    (wr_bank),
        .prev_bank  (prev_bank),
        .curr_bank  (curr_bank),
        .seq_start  (seq_start),
        .seq_done   (seq_done),
        .busy       (busy),
        .flow_valid (flow_valid),
        .flow_ack   (flow_ack),
        .timeout_err(timeout_err)
`ifdef FRAME_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got stuck, required finish");
        $fatal(1, "bench time limit");
    end

    // Reference model: phase 0 idle, 1 launch, 2 solving, 3 result waiting.
    // Banks kept as an ordered queue {prev, curr, wr}; a rotation moves the head to the tail.
    int         m_phase;
    logic [1:0] m_banks[$];
    bit         m_primed, m_pending, m_to;
    int         m_age, m_frames, m_drops;

    task automatic model_reset();
        m_phase = 0;
        m_banks = {2'd2, 2'd1, 2'd0};
        m_primed = 0; m_pending = 0; m_to = 0;
        m_age = 0; m_frames = 0; m_drops = 0;
    endtask

    task automatic model_rotate();
        logic [1:0] head;
        head = m_banks.pop_front();
        m_banks.push_back(head);
    endtask

    task automatic model_capture(input bit fi);
        if (fi) begin
            if (m_pending) m_drops++;
            else m_pending = 1;
        end
    endtask

    task automatic model_step(input bit en, input bit fi, input bit sd, input bit fa);
        int nxt;
        bit launch, expired;
        nxt = m_phase; launch = 0; expired = 0;
        m_age++;
        case (m_phase)
            0: if (en && (fi || m_pending)) begin
                if (fi && m_pending) m_drops++;
                m_pending = 0;
                model_rotate();
                if (m_primed) launch = 1;
                else m_primed = 1;
            end
            1: begin model_capture(fi); nxt = 2; end
            2: begin
                model_capture(fi);
                if (sd) begin nxt = 3; m_frames++; end
                else if (m_age >= TIMEOUT) begin nxt = 0; expired = 1; end
            end
            default: begin
                if (fa && en && (m_pending || fi)) begin
                    if (m_pending && fi) m_drops++;
                    m_pending = 0;
                    model_rotate();
                    launch = 1;
                end else begin
                    model_capture(fi);
                    if (fa) nxt = 0;
                end
            end
        endcase
        if (launch) begin nxt = 1; m_age = 0; end
        m_to = expired || (m_to && en);
        m_phase = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(enable, frame_in, seq_done, flow_ack);
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total += 7;
        if (wr_bank !== 2'd0) begin bad++; $display("FAIL reset_wr: got %0d required 0", wr_bank); end
        if (curr_bank !== 2'd1) begin bad++; $display("FAIL reset_curr: got %0d required 1", curr_bank); end
        if (prev_bank !== 2'd2) begin bad++; $display("FAIL reset_prev: got %0d required 2", prev_bank); end
        if (seq_start !== 1'b0) begin bad++; $display("FAIL reset_seq_start: got %b required 0", seq_start); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (flow_valid !== 1'b0) begin bad++; $display("FAIL reset_flow_valid: got %b required 0", flow_valid); end
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b required 0", timeout_err); end
`ifdef FRAME_STATS_EN
        total += 2;
        if (frame_cnt !== '0) begin bad++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        if (drop_cnt !== '0) begin bad++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_prime();
        enable = 1'b1;
        frame_in = 1'b1; tick(); frame_in = 1'b0;
        total += 4;
        if ({prev_bank, curr_bank, wr_bank} !== {2'd1, 2'd0, 2'd2}) begin
            bad++; $display("FAIL prime_banks1: got p%0d c%0d w%0d required p1 c0 w2", prev_bank, curr_bank, wr_bank);
        end
        if (seq_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL prime_no_start: got start=%b busy=%b required 0 0", seq_start, busy); end
        tick();
        if (seq_start !== 1'b0) begin bad++; $display("FAIL prime_idle_wait: got %b required 0", seq_start); end
        frame_in = 1'b1; tick(); frame_in = 1'b0;
        if ({prev_bank, curr_bank, wr_bank} !== {2'd0, 2'd2, 2'd1}) begin
            bad++; $display("FAIL prime_banks2: got p%0d c%0d w%0d required p0 c2 w1", prev_bank, curr_bank, wr_bank);
        end
        total += 2;
        if (seq_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL prime_start: got start=%b busy=%b required 1 1", seq_start, busy); end
        tick();
        if (seq_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL prime_start_width: got start=%b busy=%b required 0 1", seq_start, busy); end
    endtask

    task automatic test_solve();
        int high;
        repeat (8) tick();
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        high = 0;
        for (int i = 0; i < 5; i++) begin
            if (flow_valid === 1'b1) high++;
            if (i == 4) flow_ack = 1'b1;
            tick();
        end
        flow_ack = 1'b0;
        total += 3;
        if (high != 5) begin bad++; $display("FAIL solve_valid_cycles: got %0d required 5", high); end
        if (flow_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL solve_ack: got valid=%b busy=%b required 0 0", flow_valid, busy); end
        if ({prev_bank, curr_bank, wr_bank} !== {2'd0, 2'd2, 2'd1}) begin
            bad++; $display("FAIL solve_banks: got p%0d c%0d w%0d required p0 c2 w1", prev_bank, curr_bank, wr_bank);
        end
`ifdef FRAME_STATS_EN
        total += 1;
        if (frame_cnt !== 16'd1) begin bad++; $display("FAIL solve_frame_cnt: got %0d required 1", frame_cnt); end
`endif
    endtask

    task automatic test_drop();
        frame_in = 1'b1; tick(); frame_in = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            frame_in = 1'b1; tick(); frame_in = 1'b0; tick();
        end
        total += 4;
        if ({prev_bank, curr_bank, wr_bank} !== {2'd2, 2'd1, 2'd0}) begin
            bad++; $display("FAIL drop_banks_held: got p%0d c%0d w%0d required p2 c1 w0", prev_bank, curr_bank, wr_bank);
        end
`ifdef FRAME_STATS_EN
        total += 1;
        if (drop_cnt !== 16'd2) begin bad++; $display("FAIL drop_cnt: got %0d required 2", drop_cnt); end
`endif
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        if (flow_valid !== 1'b1) begin bad++; $display("FAIL drop_valid: got %b required 1", flow_valid); end
        flow_ack = 1'b1; tick(); flow_ack = 1'b0;
        if (seq_start !== 1'b1 || flow_valid !== 1'b0) begin bad++; $display("FAIL drop_relaunch: got start=%b valid=%b required 1 0", seq_start, flow_valid); end
        if ({prev_bank, curr_bank, wr_bank} !== {2'd1, 2'd0, 2'd2}) begin
            bad++; $display("FAIL drop_rotate: got p%0d c%0d w%0d required p1 c0 w2", prev_bank, curr_bank, wr_bank);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (timeout_err !== 1'b0 || flow_valid !== 1'b0) early++;
        end
        tick();
        total += 4;
        if (early != 0) begin bad++; $display("FAIL timeout_early: got %0d bad cycles required 0", early); end
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b required 1", timeout_err); end
        if (busy !== 1'b0 || flow_valid !== 1'b0) begin bad++; $display("FAIL timeout_abort: got busy=%b valid=%b required 0 0", busy, flow_valid); end
        enable = 1'b0; tick(); enable = 1'b1;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b required 0", timeout_err); end
    endtask

    task automatic test_ack_frame_and_enable();
        frame_in = 1'b1; tick(); frame_in = 1'b0;
        tick();
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        flow_ack = 1'b1; frame_in = 1'b1; tick(); flow_ack = 1'b0; frame_in = 1'b0;
        total += 6;
        if (seq_start !== 1'b1 || flow_valid !== 1'b0) begin bad++; $display("FAIL ackframe_start: got start=%b valid=%b required 1 0", seq_start, flow_valid); end
        if ({prev_bank, curr_bank, wr_bank} !== {2'd2, 2'd1, 2'd0}) begin
            bad++; $display("FAIL ackframe_banks: got p%0d c%0d w%0d required p2 c1 w0", prev_bank, curr_bank, wr_bank);
        end
        tick();
        enable = 1'b0;
        frame_in = 1'b1; tick(); frame_in = 1'b0;
        seq_done = 1'b1; tick(); seq_done = 1'b0;
        if (flow_valid !== 1'b1) begin bad++; $display("FAIL enlow_solve_completes: got %b required 1", flow_valid); end
        flow_ack = 1'b1; tick(); flow_ack = 1'b0;
        tick(); tick();
        if (busy !== 1'b0 || seq_start !== 1'b0) begin bad++; $display("FAIL enlow_wait: got busy=%b start=%b required 0 0", busy, seq_start); end
        enable = 1'b1; tick();
        if (seq_start !== 1'b1) begin bad++; $display("FAIL enlow_resume_start: got %b required 1", seq_start); end
        if ({prev_bank, curr_bank, wr_bank} !== {2'd1, 2'd0, 2'd2}) begin
            bad++; $display("FAIL enlow_resume_banks: got p%0d c%0d w%0d required p1 c0 w2", prev_bank, curr_bank, wr_bank);
        end
`ifdef FRAME_STATS_EN
        total += 1;
        if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ackframe_drop_cnt: got %0d required 2", drop_cnt); end
`endif
    endtask

    task automatic test_async_reset();
        repeat (4) tick();
        #3 rst_n = 1'b0;
        #1;
        total += 5;
        if ({prev_bank, curr_bank, wr_bank} !== {2'd2, 2'd1, 2'd0}) begin
            bad++; $display("FAIL areset_banks: got p%0d c%0d w%0d required p2 c1 w0", prev_bank, curr_bank, wr_bank);
        end
        if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy: got %b required 0", busy); end
        if (seq_start !== 1'b0) begin bad++; $display("FAIL areset_start: got %b required 0", seq_start); end
        if (flow_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b required 0", flow_valid); end
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL areset_timeout: got %b required 0", timeout_err); end
`ifdef FRAME_STATS_EN
        total += 1;
        if (frame_cnt !== '0 || drop_cnt !== '0) begin bad++; $display("FAIL areset_counters: got f%0d d%0d required 0 0", frame_cnt, drop_cnt); end
`endif
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            enable   = ($urandom_range(0, 99) < 85);
            frame_in = ($urandom_range(0, 99) < 10);
            seq_done = ($urandom_range(0, 99) < 3);
            flow_ack = ($urandom_range(0, 99) < 20);
            tick();
            total += 4;
            if ({prev_bank, curr_bank, wr_bank} !== {m_banks[0], m_banks[1], m_banks[2]}) begin
                bad++; $display("FAIL rnd_banks @%0d: got p%0d c%0d w%0d required p%0d c%0d w%0d",
                                cyc, prev_bank, curr_bank, wr_bank, m_banks[0], m_banks[1], m_banks[2]);
            end
            if ({seq_start, flow_valid, busy} !== {m_phase == 1, m_phase == 3, m_phase != 0}) begin
                bad++; $display("FAIL rnd_ctrl @%0d: got start=%b valid=%b busy=%b required phase %0d",
                                cyc, seq_start, flow_valid, busy, m_phase);
            end
            if (timeout_err !== m_to) begin bad++; $display("FAIL rnd_timeout @%0d: got %b required %b", cyc, timeout_err, m_to); end
            if ((m_banks[0] == m_banks[1]) || (m_banks[1] == m_banks[2]) || (prev_bank == curr_bank) || (curr_bank == wr_bank) || (prev_bank == wr_bank)) begin
                bad++; $display("FAIL rnd_perm @%0d: got p%0d c%0d w%0d required permutation", cyc, prev_bank, curr_bank, wr_bank);
            end
`ifdef FRAME_STATS_EN
            total += 1;
            if ({frame_cnt, drop_cnt} !== {m_frames[CW-1:0], m_drops[CW-1:0]}) begin
                bad++; $display("FAIL rnd_counters @%0d: got f%0d d%0d required f%0d d%0d",
                                cyc, frame_cnt, drop_cnt, m_frames[CW-1:0], m_drops[CW-1:0]);
            end
`endif
        end
        enable = 1'b0; frame_in = 1'b0; seq_done = 1'b0; flow_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prime();
        test_solve();
        test_drop();
        test_timeout();
        test_ack_frame_and_enable();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
